alu_mc: RTL and testbench
=========================

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter DATA_W, default 16: operand/result width, at least 4.
REQ-002 Parameter CNT_W, default $clog2(DATA_W)+1: multiply iteration counter width.
REQ-003 Port clock, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port start, input, 1: operation request, sampled on the rising edge.
REQ-006 Port op, input, 3: opcode, sampled with start.
REQ-007 Port a, input, DATA_W: operand A, sampled with start.
REQ-008 Port b, input, DATA_W: operand B, sampled with start.
REQ-009 Port result, output, DATA_W: registered result, low half for MUL.
REQ-010 Port result_hi, output, DATA_W: MUL upper half; 0 for all other ops.
REQ-011 Port carry, output, 1: ADD carry-out, SUB/INC borrow/carry, 0 otherwise.
REQ-012 Port zero, output, 1: high when the full registered result is all zero ({result_hi,result} for MUL).
REQ-013 Port busy, output, 1: operation in progress.
REQ-014 Port done, output, 1: one-cycle completion pulse.

Function
REQ-015 Opcodes SHALL be: 000 ADD a+b, 001 SUB a-b, 010 MUL a*b unsigned, 011 AND, 100 OR, 101 PASSB b, 110 INC a+1, 111 CLR 0.
REQ-016 Arithmetic SHALL wrap modulo 2^DATA_W; carry = bit DATA_W of the (DATA_W+1)-bit sum; SUB carry = 1 when a < b.
REQ-017 State machine SHALL have IDLE, EXEC, MUL, DONE; reset state IDLE.
REQ-018 IDLE: start=1 at edge E0 latches op/a/b; goes to MUL if op=010, else EXEC; busy=1 after E0.
REQ-019 EXEC: at edge E1, result/carry/zero registered; goes to DONE.
REQ-020 MUL: shift-add, one multiplier bit per edge, E1..E(DATA_W); at E(DATA_W), {result_hi,result} registered; goes to DONE.
REQ-021 DONE: done=1, busy=0 for exactly one cycle; outputs valid.
REQ-022 Latency SHALL be 1 edge after acceptance for non-MUL ops and DATA_W edges for MUL (16 for the default).
REQ-023 DONE: start=1 SHALL be accepted as in IDLE (back-to-back, no bubble); otherwise go to IDLE.
REQ-024 start while busy=1 (EXEC/MUL) SHALL be ignored: no latch, no error, no effect on the in-flight op.
REQ-025 result/result_hi/carry/zero SHALL hold their last value from done until the next completion; they SHALL NOT change during EXEC or MUL.
REQ-026 Inputs a/b/op changing after acceptance SHALL NOT affect the in-flight op.
REQ-027 done and busy SHALL never be high together.
REQ-028 op=X/undefined is not supported; all 8 encodings are legal.

Reset
REQ-029 reset=1 at a rising edge SHALL force IDLE and clear result=0, result_hi=0, carry=0, busy=0, done=0, counter=0, and zero=1.
REQ-030 reset SHALL take priority over start at the same edge; start is not accepted.
REQ-031 reset mid-EXEC/MUL SHALL abort the op with no done pulse; the next start SHALL run normally.

Verification (DATA_W=16)
REQ-032 ADD: a=3, b=2 -> done one edge after acceptance, result=5, carry=0, zero=0, result_hi=0.
REQ-033 SUB: a=2, b=3 -> result=0xFFFF, carry=1; ADD 0xFFFF+1 -> result=0, carry=1, zero=1.
REQ-034 MUL: a=3, b=2 -> busy for 16 edges, done after edge 16, result=6, result_hi=0; then 0xFFFF*0xFFFF -> result=0x0001, result_hi=0xFFFE.
REQ-035 start pulsed with ADD 1+1 during MUL -> ignored; the MUL result is unchanged and there is only one done pulse.
REQ-036 reset at edge 8 of MUL -> no done, all outputs at reset values; next INC a=0x7 -> result=0x8 after 1 edge.
REQ-037 start held high in DONE with PASSB b=0x1234 -> accepted back-to-back; done on the following cycle, result=0x1234.

Source files
------------

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-edge logic/add ops and a shift-add unsigned multiply.
// Results are registered only on completion and hold until the next completion.
module alu_mc #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = $clog2(DATA_W) + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic [DATA_W-1:0] result_hi,
    output logic              carry,
    output logic              zero,
    output logic              busy,
    output logic              done
);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_PASS = 3'b101;
    localparam logic [2:0] OP_INC  = 3'b110;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_DONE} state_t;

    state_t            state, state_n;
    logic [2:0]        op_q;
    logic [DATA_W-1:0] a_q, b_q;
    logic [DATA_W-1:0] prod_hi, prod_lo;
    logic [CNT_W-1:0]  cnt;

    logic              accept, mul_last;
    logic [DATA_W:0]   sum, diff, inc, step_sum;
    logic [DATA_W-1:0] exec_res, next_hi, next_lo;
    logic              exec_c;

    assign accept   = start && (state == S_IDLE || state == S_DONE);
    assign mul_last = (cnt == CNT_W'(DATA_W - 1));
    assign busy     = (state == S_EXEC) || (state == S_MUL);
    assign done     = (state == S_DONE);

    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE, S_DONE: begin
                if (start) state_n = (op == OP_MUL) ? S_MUL : S_EXEC;
                else       state_n = S_IDLE;
            end
            S_EXEC:  state_n = S_DONE;
            S_MUL:   if (mul_last) state_n = S_DONE;
            default: state_n = S_IDLE;
        endcase
    end

    // Extended arithmetic: bit DATA_W is carry for add/inc and borrow for sub.
    always_comb begin
        sum      = {1'b0, a_q} + {1'b0, b_q};
        diff     = {1'b0, a_q} - {1'b0, b_q};
        inc      = {1'b0, a_q} + (DATA_W + 1)'(1);
        exec_res = '0;
        exec_c   = 1'b0;
        case (op_q)
            OP_ADD:  begin exec_res = sum[DATA_W-1:0];  exec_c = sum[DATA_W];  end
            OP_SUB:  begin exec_res = diff[DATA_W-1:0]; exec_c = diff[DATA_W]; end
            OP_AND:  exec_res = a_q & b_q;
            OP_OR:   exec_res = a_q | b_q;
            OP_PASS: exec_res = b_q;
            OP_INC:  begin exec_res = inc[DATA_W-1:0];  exec_c = inc[DATA_W];  end
            default: exec_res = '0;
        endcase
    end

    // One multiplier bit per edge: conditionally add a, then shift {hi,lo} right.
    always_comb begin
        step_sum = {1'b0, prod_hi} + (prod_lo[0] ? {1'b0, a_q} : '0);
        next_hi  = step_sum[DATA_W:1];
        next_lo  = {step_sum[0], prod_lo[DATA_W-1:1]};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            prod_hi   <= '0;
            prod_lo   <= '0;
            cnt       <= '0;
            result    <= '0;
            result_hi <= '0;
            carry     <= 1'b0;
            zero      <= 1'b1;
        end else if (accept) begin
            op_q    <= op;
            a_q     <= a;
            b_q     <= b;
            prod_hi <= '0;
            prod_lo <= b;
            cnt     <= '0;
        end else if (state == S_EXEC) begin
            result    <= exec_res;
            result_hi <= '0;
            carry     <= exec_c;
            zero      <= ~|exec_res;
        end else if (state == S_MUL) begin
            prod_hi <= next_hi;
            prod_lo <= next_lo;
            cnt     <= cnt + CNT_W'(1);
            if (mul_last) begin
                result    <= next_lo;
                result_hi <= next_hi;
                carry     <= 1'b0;
                zero      <= ~|{next_hi, next_lo};
            end
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc: expected results are queued on issue and
// popped when done is observed.
module tb_alu_mc;

    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] r;
        logic [W-1:0] hi;
        logic         c;
        logic         z;
    } exp_t;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [2:0]   op    = 3'd0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic [W-1:0] result, result_hi;
    logic         carry, zero, busy, done;

    exp_t         sb[$];
    int           n_tests = 0;
    int           n_fail  = 0;
    logic [W-1:0] last_r  = '0;

    alu_mc #(.DATA_W(W)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .result(result), .result_hi(result_hi), .carry(carry), .zero(zero),
        .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // busy and done are mutually exclusive on every cycle
    always @(negedge clock) begin
        if (!reset) check("busy_done_excl", {30'd0, busy, done} & 32'h3, (busy & done) ? 32'h2 : {30'd0, busy, done});
    end

    function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t        e;
        logic [W:0]  s;
        logic [31:0] p;
        e = '0;
        case (o)
            3'd0: begin s = {1'b0, x} + {1'b0, y}; e.r = s[W-1:0]; e.c = s[W]; end
            3'd1: begin e.r = x - y; e.c = (x < y); end
            3'd2: begin p = {16'd0, x} * {16'd0, y}; e.r = p[15:0]; e.hi = p[31:16]; end
            3'd3: e.r = x & y;
            3'd4: e.r = x | y;
            3'd5: e.r = y;
            3'd6: begin s = {1'b0, x} + 17'd1; e.r = s[W-1:0]; e.c = s[W]; end
            default: e.r = '0;
        endcase
        e.z = ({e.hi, e.r} == '0);
        return e;
    endfunction

    // Drive start for one edge from a negedge; returns at the negedge after acceptance.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        start = 1'b1; op = o; a = x; b = y;
        sb.push_back(model(o, x, y));
        @(negedge clock);
        start = 1'b0;
        op = 3'($urandom); a = W'($urandom); b = W'($urandom);
        check("busy_after_accept", {31'd0, busy}, 32'd1);
        check("hold_during_busy", {16'd0, result}, {16'd0, last_r});
    endtask

    task automatic wait_done(input string tag, input int lat);
        int   n;
        exp_t e;
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_lat"}, n, lat);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({tag, "_result"}, {16'd0, result}, {16'd0, e.r});
            check({tag, "_result_hi"}, {16'd0, result_hi}, {16'd0, e.hi});
            check({tag, "_carry"}, {31'd0, carry}, {31'd0, e.c});
            check({tag, "_zero"}, {31'd0, zero}, {31'd0, e.z});
            last_r = e.r;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_result"}, {16'd0, result}, 32'd0);
        check({tag, "_result_hi"}, {16'd0, result_hi}, 32'd0);
        check({tag, "_carry"}, {31'd0, carry}, 32'd0);
        check({tag, "_zero"}, {31'd0, zero}, 32'd1);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        logic [2:0] ro;

        // reset state
        @(negedge clock); @(negedge clock);
        reset = 1'b0;
        check_reset_vals("rst");

        // basic arithmetic vectors
        issue(3'd0, 16'd3, 16'd2);           wait_done("add_3_2", 1);
        check("add_3_2_const", {16'd0, result}, 32'd5);
        @(negedge clock);
        check("done_one_cycle", {31'd0, done}, 32'd0);
        issue(3'd1, 16'd2, 16'd3);           wait_done("sub_2_3", 1);
        check("sub_const", {15'd0, carry, result}, {15'd0, 1'b1, 16'hFFFF});
        issue(3'd0, 16'hFFFF, 16'd1);        wait_done("add_wrap", 1);
        check("add_wrap_zero", {31'd0, zero}, 32'd1);

        // multiply
        issue(3'd2, 16'd3, 16'd2);           wait_done("mul_3_2", 16);
        issue(3'd2, 16'hFFFF, 16'hFFFF);     wait_done("mul_ff", 16);
        check("mul_ff_const", {result_hi, result}, 32'hFFFE_0001);
        @(negedge clock);

        // remaining opcodes, then a few random operations
        issue(3'd3, 16'hF0F0, 16'h3C3C);     wait_done("and", 1);
        issue(3'd4, 16'hF0F0, 16'h0F0F);     wait_done("or", 1);
        issue(3'd6, 16'hFFFF, 16'd0);        wait_done("inc_wrap", 1);
        issue(3'd7, 16'h1234, 16'h5678);     wait_done("clr", 1);
        for (int i = 0; i < 6; i++) begin
            ro = 3'($urandom);
            issue(ro, W'($urandom), W'($urandom));
            wait_done("rand", (ro == 3'd2) ? 16 : 1);
            if (i[0]) @(negedge clock);
        end
        @(negedge clock);

        // start during MUL is ignored, single done pulse
        issue(3'd2, 16'd5, 16'd7);
        repeat (3) @(negedge clock);
        start = 1'b1; op = 3'd0; a = 16'd1; b = 16'd1;
        @(negedge clock);
        start = 1'b0;
        wait_done("mul_ignore", 12);
        pulses = 0;
        repeat (6) begin
            @(negedge clock);
            if (done === 1'b1) pulses++;
        end
        check("mul_ignore_pulses", pulses, 32'd0);
        check("mul_ignore_idle", {31'd0, busy}, 32'd0);

        // reset at the 8th MUL edge aborts it
        issue(3'd2, 16'h00FF, 16'h0101);
        repeat (7) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        sb.delete();
        last_r = '0;
        check_reset_vals("mul_abort");
        pulses = 0;
        repeat (20) begin
            @(negedge clock);
            if (done === 1'b1) pulses++;
        end
        check("mul_abort_no_done", pulses, 32'd0);
        issue(3'd6, 16'h0007, 16'd0);        wait_done("inc_after_abort", 1);
        check("inc_const", {16'd0, result}, 32'h8);

        // back-to-back: start in DONE is accepted with no bubble
        issue(3'd5, 16'd0, 16'h1234);        wait_done("passb_b2b", 1);
        check("passb_const", {16'd0, result}, 32'h1234);
        @(negedge clock);

        // reset wins over start at the same edge
        start = 1'b1; op = 3'd0; a = 16'd9; b = 16'd9; reset = 1'b1;
        @(negedge clock);
        reset = 1'b0; start = 1'b0;
        last_r = '0;
        check_reset_vals("rst_prio");
        @(negedge clock);
        check("rst_prio_not_accepted", {31'd0, busy}, 32'd0);

        // normal operation after that reset
        issue(3'd0, 16'h8000, 16'h8000);     wait_done("add_carry_zero", 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
